// File: rtl/tpg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpg_pkg
// Description : Shared definitions for the timing pulse generator: default
//               sizing parameters and the run-state encoding. The ARMED
//               state is only reachable when TPG_EXT_TRIG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package tpg_pkg;

    localparam int TPG_N_CH_DEF   = 4;
    localparam int TPG_CNT_W_DEF  = 16;
    localparam int TPG_NCYC_W_DEF = 20;

    localparam int         ST_W     = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;

endpackage : tpg_pkg
`default_nettype wire

// File: rtl/tpg_channel.sv
`default_nettype none
// ============================================================================
// Module      : tpg_channel
// Description : One pulse channel. Compares the shared in-cycle counter with
//               this channel's rise offset and rise+width end point and holds
//               the registered pulse output. The pulse is always cleared on
//               the wrap edge so it can never span two cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tpg_channel
    import tpg_pkg::*;
#(
    parameter int CNT_W = TPG_CNT_W_DEF
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             clr_i,      // start/stop edge: drop the pulse
    input  logic             run_i,      // counter is advancing this clock
    input  logic             wrap_i,     // counter == period this clock
    input  logic             en_i,
    input  logic [CNT_W-1:0] counter_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] rise_i,
    input  logic [CNT_W-1:0] width_i,
    output logic             pulse_o
);

    logic             pulse_q;
    logic             pulse_d;
    logic [CNT_W:0]   w_fall_at;
    logic             w_can_fire;
    logic             w_rise_hit;
    logic             w_fall_hit;

    // The end point is one bit wider so rise+width never aliases back into
    // the cycle; such a pulse is then ended by the wrap instead.
    assign w_fall_at  = {1'b0, rise_i} + {1'b0, width_i};
    assign w_can_fire = en_i && (width_i != '0) && (rise_i <= period_i);
    assign w_rise_hit = w_can_fire && (counter_i == rise_i);
    assign w_fall_hit = ({1'b0, counter_i} == w_fall_at);

    // Next pulse value: clear beats wrap beats rise beats fall.
    always_comb begin
        pulse_d = pulse_q;
        if (clr_i) begin
            pulse_d = 1'b0;
        end else if (run_i) begin
            if (wrap_i) begin
                pulse_d = 1'b0;
            end else if (w_rise_hit) begin
                pulse_d = 1'b1;
            end else if (w_fall_hit) begin
                pulse_d = 1'b0;
            end
        end
    end

    // Pulse output register.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule : tpg_channel
`default_nettype wire

// File: rtl/timing_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : timing_pulse_gen
// Description : Multi-channel periodic pulse generator. A start pulse latches
//               the configuration into shadow registers and runs max_cycle
//               cycles of period+1 clocks (max_cycle=0 runs forever); each
//               channel emits one pulse per cycle at its rise offset.
//               Optional feature macro: TPG_EXT_TRIG_EN adds ext_trig and
//               trig_mode; with trig_mode=1 each synchronised ext_trig rising
//               edge runs exactly one cycle from the ARMED state.
// Revision    : 1.0 - initial release
// ============================================================================
module timing_pulse_gen
    import tpg_pkg::*;
#(
    parameter int N_CH   = TPG_N_CH_DEF,
    parameter int CNT_W  = TPG_CNT_W_DEF,
    parameter int NCYC_W = TPG_NCYC_W_DEF
) (
    input  logic                  clk_50M,
    input  logic                  rst_n,
`ifdef TPG_EXT_TRIG_EN
    input  logic                  ext_trig,
    input  logic                  trig_mode,
`endif
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNT_W-1:0]      period,
    input  logic [NCYC_W-1:0]     max_cycle,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH*CNT_W-1:0] rise,
    input  logic [N_CH*CNT_W-1:0] width,
    output logic [N_CH-1:0]       pulse,
    output logic                  busy,
    output logic [NCYC_W-1:0]     cycle_num,
    output logic                  done
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NCYC_W-1:0] NCYC_ONE = {{(NCYC_W-1){1'b0}}, 1'b1};

    logic [ST_W-1:0]       state_q,     state_d;
    logic [CNT_W-1:0]      counter_q,   counter_d;
    logic [NCYC_W-1:0]     cycle_num_q, cycle_num_d;
    logic                  done_q,      done_d;

    // Shadow copies of the configuration, only loaded on start.
    logic [CNT_W-1:0]      period_q,    period_d;
    logic [NCYC_W-1:0]     max_cycle_q, max_cycle_d;
    logic [N_CH-1:0]       ch_en_q,     ch_en_d;
    logic [N_CH*CNT_W-1:0] rise_q,      rise_d;
    logic [N_CH*CNT_W-1:0] width_q,     width_d;

    logic                  w_run;
    logic                  w_wrap;
    logic                  w_last;
    logic                  w_clr;

`ifdef TPG_EXT_TRIG_EN
    logic                  trig_mode_q, trig_mode_d;
    logic                  trig_meta_q;
    logic                  trig_sync_q;
    logic                  trig_prev_q;
    logic                  w_trig_rise;

    assign w_trig_rise = trig_sync_q && !trig_prev_q;

    // Two-flop synchroniser plus one delay stage for rising-edge detection.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            trig_meta_q <= 1'b0;
            trig_sync_q <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            trig_meta_q <= ext_trig;
            trig_sync_q <= trig_meta_q;
            trig_prev_q <= trig_sync_q;
        end
    end
`endif

    assign w_run  = (state_q == ST_RUN);
    assign w_wrap = w_run && (counter_q == period_q);
    assign w_last = (max_cycle_q != '0) && (cycle_num_q == (max_cycle_q - NCYC_ONE));

    // Run control: stop beats start, start (re)loads the shadows, otherwise
    // the counter advances and the wrap decides continue / re-arm / finish.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        cycle_num_d = cycle_num_q;
        done_d      = 1'b0;
        period_d    = period_q;
        max_cycle_d = max_cycle_q;
        ch_en_d     = ch_en_q;
        rise_d      = rise_q;
        width_d     = width_q;
        w_clr       = 1'b0;
`ifdef TPG_EXT_TRIG_EN
        trig_mode_d = trig_mode_q;
`endif
        if (stop) begin
            state_d     = ST_IDLE;
            counter_d   = '0;
            cycle_num_d = '0;
            w_clr       = 1'b1;
        end else if (start) begin
            period_d    = period;
            max_cycle_d = max_cycle;
            ch_en_d     = ch_en;
            rise_d      = rise;
            width_d     = width;
            counter_d   = '0;
            cycle_num_d = '0;
            w_clr       = 1'b1;
`ifdef TPG_EXT_TRIG_EN
            trig_mode_d = trig_mode;
            state_d     = trig_mode ? ST_ARMED : ST_RUN;
`else
            state_d     = ST_RUN;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (w_wrap) begin
                        counter_d = '0;
                        if (w_last) begin
                            state_d     = ST_IDLE;
                            cycle_num_d = '0;
                            done_d      = 1'b1;
                        end else begin
                            cycle_num_d = cycle_num_q + NCYC_ONE;
`ifdef TPG_EXT_TRIG_EN
                            if (trig_mode_q) begin
                                state_d = ST_ARMED;
                            end
`endif
                        end
                    end else begin
                        counter_d = counter_q + CNT_ONE;
                    end
                end
`ifdef TPG_EXT_TRIG_EN
                ST_ARMED: begin
                    if (w_trig_rise) begin
                        state_d = ST_RUN;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control and shadow registers.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            counter_q   <= '0;
            cycle_num_q <= '0;
            done_q      <= 1'b0;
            period_q    <= '0;
            max_cycle_q <= '0;
            ch_en_q     <= '0;
            rise_q      <= '0;
            width_q     <= '0;
`ifdef TPG_EXT_TRIG_EN
            trig_mode_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            cycle_num_q <= cycle_num_d;
            done_q      <= done_d;
            period_q    <= period_d;
            max_cycle_q <= max_cycle_d;
            ch_en_q     <= ch_en_d;
            rise_q      <= rise_d;
            width_q     <= width_d;
`ifdef TPG_EXT_TRIG_EN
            trig_mode_q <= trig_mode_d;
`endif
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            tpg_channel #(
                .CNT_W (CNT_W)
            ) u_channel (
                .clk_50M   (clk_50M),
                .rst_n     (rst_n),
                .clr_i     (w_clr),
                .run_i     (w_run),
                .wrap_i    (w_wrap),
                .en_i      (ch_en_q[gi]),
                .counter_i (counter_q),
                .period_i  (period_q),
                .rise_i    (rise_q[gi*CNT_W +: CNT_W]),
                .width_i   (width_q[gi*CNT_W +: CNT_W]),
                .pulse_o   (pulse[gi])
            );
        end
    endgenerate

    assign busy      = (state_q != ST_IDLE);
    assign cycle_num = cycle_num_q;
    assign done      = done_q;

endmodule : timing_pulse_gen
`default_nettype wire

// File: tb/tb_timing_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_timing_pulse_gen
// Description : Directed self-checking bench for timing_pulse_gen. Inputs are
//               driven and outputs sampled on the falling clock edge; sample
//               s=1 is the first falling edge after the start edge, so the
//               in-cycle counter seen at sample s is (s-1) mod (period+1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timing_pulse_gen;

    localparam int N_CH   = 4;
    localparam int CNT_W  = 16;
    localparam int NCYC_W = 20;

    logic                  clk_50M;
    logic                  rst_n;
    logic                  start;
    logic                  stop;
    logic [CNT_W-1:0]      period;
    logic [NCYC_W-1:0]     max_cycle;
    logic [N_CH-1:0]       ch_en;
    logic [N_CH*CNT_W-1:0] rise;
    logic [N_CH*CNT_W-1:0] width;
    logic [N_CH-1:0]       pulse;
    logic                  busy;
    logic [NCYC_W-1:0]     cycle_num;
    logic                  done;
`ifdef TPG_EXT_TRIG_EN
    logic                  ext_trig;
    logic                  trig_mode;
`endif

    int n_checks;
    int n_fail;

    timing_pulse_gen #(
        .N_CH   (N_CH),
        .CNT_W  (CNT_W),
        .NCYC_W (NCYC_W)
    ) dut (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
`ifdef TPG_EXT_TRIG_EN
        .ext_trig  (ext_trig),
        .trig_mode (trig_mode),
`endif
        .start     (start),
        .stop      (stop),
        .period    (period),
        .max_cycle (max_cycle),
        .ch_en     (ch_en),
        .rise      (rise),
        .width     (width),
        .pulse     (pulse),
        .busy      (busy),
        .cycle_num (cycle_num),
        .done      (done)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_50M);
    endtask

    task automatic set_ch(input int ch, input int r, input int w);
        rise[ch*CNT_W +: CNT_W]  = CNT_W'(r);
        width[ch*CNT_W +: CNT_W] = CNT_W'(w);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int p_hi [N_CH];
    int rises, first_rise, last_rise, done_cnt, done_s, done_busy, max_cyc, bad0, bad1, junk;
    logic prev_p0;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        period = '0; max_cycle = '0; ch_en = '0; rise = '0; width = '0;
`ifdef TPG_EXT_TRIG_EN
        ext_trig = 1'b0; trig_mode = 1'b0;
`endif
        repeat (3) tick();
        check("rst_pulse", 32'(pulse), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cycle_num", 32'(cycle_num), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // ---- A: 8 cycles of 513 clocks, ch0 2-clock pulse, ch1..3 silent
        period = 16'd512; max_cycle = 20'd8; ch_en = 4'b1101;
        set_ch(0, 0, 2); set_ch(1, 10, 3); set_ch(2, 16'h80, 0); set_ch(3, 16'hF000, 5);
        do_start();
        check("A_busy_after_start", 32'(busy), 1);
        foreach (p_hi[i]) p_hi[i] = 0;
        rises = 0; first_rise = -1; last_rise = -1; done_cnt = 0; done_s = -1;
        done_busy = -1; max_cyc = 0; prev_p0 = 1'b0;
        for (int s = 1; s <= 4200; s++) begin
            for (int c = 0; c < N_CH; c++) p_hi[c] += int'(pulse[c]);
            if (pulse[0] && !prev_p0) begin
                rises++;
                if (first_rise < 0) first_rise = s;
                last_rise = s;
            end
            prev_p0 = pulse[0];
            if (done) begin done_cnt++; done_s = s; done_busy = int'(busy); end
            if (int'(cycle_num) > max_cyc) max_cyc = int'(cycle_num);
            tick();
        end
        check("A_p0_high_clocks", 32'(p_hi[0]), 16);
        check("A_p0_rises", 32'(rises), 8);
        check("A_first_rise_sample", 32'(first_rise), 2);
        check("A_last_rise_sample", 32'(last_rise), 3593);
        check("A_p1_disabled", 32'(p_hi[1]), 0);
        check("A_p2_zero_width", 32'(p_hi[2]), 0);
        check("A_p3_rise_gt_period", 32'(p_hi[3]), 0);
        check("A_done_count", 32'(done_cnt), 1);
        check("A_done_sample", 32'(done_s), 4105);
        check("A_busy_at_done", 32'(done_busy), 0);
        check("A_max_cycle_num", 32'(max_cyc), 7);
        check("A_busy_end", 32'(busy), 0);
        check("A_cycle_num_end", 32'(cycle_num), 0);

        // ---- B: late rise clipped at wrap; live input changes ignored
        period = 16'd100; max_cycle = 20'd3; ch_en = 4'b0011;
        set_ch(0, 0, 1); set_ch(1, 99, 5);
        do_start();
        p_hi[0] = 0; p_hi[1] = 0; bad0 = 0; bad1 = 0; done_cnt = 0; done_s = -1;
        for (int s = 1; s <= 400; s++) begin
            if (s == 50) begin
                set_ch(0, 10, 1); set_ch(1, 99, 50);
                period = 16'd20; max_cycle = 20'd1;
            end
            if (pulse[0]) begin p_hi[0]++; if (((s - 1) % 101) != 1) bad0++; end
            if (pulse[1]) begin p_hi[1]++; if (((s - 1) % 101) != 100) bad1++; end
            if (done) begin done_cnt++; done_s = s; end
            tick();
        end
        check("B_p0_high_clocks", 32'(p_hi[0]), 3);
        check("B_p0_misplaced", 32'(bad0), 0);
        check("B_p1_high_clocks", 32'(p_hi[1]), 3);
        check("B_p1_misplaced", 32'(bad1), 0);
        check("B_done_count", 32'(done_cnt), 1);
        check("B_done_sample", 32'(done_s), 304);

        // ---- C: stop mid-pulse in cycle 3 of a free run; start+stop together
        period = 16'd100; max_cycle = 20'd0; ch_en = 4'b0001;
        set_ch(0, 40, 20);
        do_start();
        for (int s = 1; s < 354; s++) tick();
        check("C_cycle_num_before_stop", 32'(cycle_num), 3);
        check("C_pulse_before_stop", 32'(pulse[0]), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("C_pulse_after_stop", 32'(pulse), 0);
        check("C_busy_after_stop", 32'(busy), 0);
        check("C_cycle_num_after_stop", 32'(cycle_num), 0);
        junk = 0;
        for (int s = 0; s < 200; s++) begin
            junk += int'(done) + int'(busy) + int'(pulse != 0);
            tick();
        end
        check("C_quiet_after_stop", 32'(junk), 0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("C_start_stop_idle", 32'(busy), 0);
        junk = 0;
        for (int s = 0; s < 30; s++) begin
            junk += int'(busy) + int'(pulse != 0) + int'(done);
            tick();
        end
        check("C_start_stop_quiet", 32'(junk), 0);

        // ---- D: restart mid-pulse, then asynchronous reset mid-pulse
        period = 16'd100; max_cycle = 20'd0; ch_en = 4'b0001;
        set_ch(0, 5, 10);
        do_start();
        for (int s = 1; s < 9; s++) tick();
        check("D_pulse_before_restart", 32'(pulse[0]), 1);
        set_ch(0, 20, 10);
        do_start();
        check("D_restart_clears_pulse", 32'(pulse[0]), 0);
        check("D_restart_busy", 32'(busy), 1);
        junk = 0;
        for (int s = 1; s < 22; s++) begin
            junk += int'(pulse[0]);
            tick();
        end
        check("D_early_pulses_after_restart", 32'(junk), 0);
        check("D_pulse_new_rise", 32'(pulse[0]), 1);
        rst_n = 1'b0;
        #1;
        check("D_async_rst_pulse", 32'(pulse), 0);
        check("D_async_rst_busy", 32'(busy), 0);
        check("D_async_rst_done", 32'(done), 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("D_idle_after_rst", 32'(busy), 0);

`ifdef TPG_EXT_TRIG_EN
        // ---- E: externally triggered single cycles
        period = 16'd10; max_cycle = 20'd3; ch_en = 4'b0001;
        set_ch(0, 2, 3);
        trig_mode = 1'b1;
        do_start();
        check("E_armed_busy", 32'(busy), 1);
        junk = 0;
        for (int s = 0; s < 20; s++) begin
            junk += int'(pulse[0]) + int'(cycle_num != 0);
            tick();
        end
        check("E_armed_waits", 32'(junk), 0);
        for (int t = 0; t < 3; t++) begin
            ext_trig = 1'b1;
            p_hi[0] = 0; done_cnt = 0;
            for (int j = 0; j < 40; j++) begin
                if (j == 3) ext_trig = 1'b0;
                p_hi[0] += int'(pulse[0]);
                done_cnt += int'(done);
                tick();
            end
            check($sformatf("E_trig%0d_highs", t), 32'(p_hi[0]), 3);
            if (t < 2) begin
                check($sformatf("E_trig%0d_cycle_num", t), 32'(cycle_num), 32'(t + 1));
                check($sformatf("E_trig%0d_busy", t), 32'(busy), 1);
                check($sformatf("E_trig%0d_no_done", t), 32'(done_cnt), 0);
            end else begin
                check("E_final_done", 32'(done_cnt), 1);
                check("E_final_busy", 32'(busy), 0);
                check("E_final_cycle_num", 32'(cycle_num), 0);
            end
        end
        trig_mode = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_timing_pulse_gen
`default_nettype wire
